// File: rtl/rsh_pkg.sv
// Shared definitions for the iterative right shifter.
//   W           : operand width
//   SW          : shift-amount width, clog2(W+1)
//   rsh_state_t : controller states
package rsh_pkg;

  localparam int unsigned W  = 7;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rsh_state_t;

endpackage

// File: rtl/rsh_iter.sv
// Iterative right shifter: shifts the operand one bit per clock, with logical or
// arithmetic fill, behind a start/ready/done handshake.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request a shift, accepted only while ready
//   a     : operand, sampled on an accepted start
//   f     : shift amount, sampled on an accepted start
//   arith : 1 = sign fill, 0 = zero fill, sampled on an accepted start
//   ready : idle and able to accept start
//   done  : one-cycle pulse, y holds the final result
//   y     : result register, held until the next accepted start
module rsh_iter #(
  parameter int unsigned W  = rsh_pkg::W,
  parameter int unsigned SW = rsh_pkg::SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] f,
  input  logic          arith,
  output logic          ready,
  output logic          done,
  output logic [W-1:0]  y
);

  import rsh_pkg::*;

  localparam logic [SW-1:0] CntOne = SW'(1);

  rsh_state_t    state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          fill_q, fill_d;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          y_d     = a;
          cnt_d   = f;
          fill_d  = arith & a[W-1];
          state_d = (f == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        y_d   = {fill_q, y_q[W-1:1]};
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // Handshake outputs come from registered state only.
  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign y     = y_q;

endmodule

// File: tb/tb_rsh_iter.sv
module tb_rsh_iter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] a;
  logic [2:0] f;
  logic       arith;
  logic       ready;
  logic       done;
  logic [6:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rsh_iter #(
    .W (7),
    .SW(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .f    (f),
    .arith(arith),
    .ready(ready),
    .done (done),
    .y    (y)
  );

  typedef struct {
    logic [6:0] a;
    logic [2:0] f;
    logic       arith;
    logic [6:0] exp_y;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called in the second half of an idle cycle (cycle 0). Inputs are scrambled
  // once accepted so any late sampling shows up in the result.
  task automatic run_op(input logic [6:0] av, input logic [2:0] fv, input logic ar,
                        input logic [6:0] exp_y);
    int n;
    n = int'(fv);
    check("ready_before_start", int'(ready), 1);
    start = 1'b1;
    a     = av;
    f     = fv;
    arith = ar;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    f     = ~fv;
    arith = ~ar;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      check($sformatf("done_c%0d_f%0d", k, n), int'(done), (k == n + 1) ? 1 : 0);
      if (k <= n) check($sformatf("busy_c%0d_f%0d", k, n), int'(ready), 0);
      if (k == n + 1) check($sformatf("y_a%0h_f%0d_ar%0d", av, n, ar), int'(y), int'(exp_y));
    end
    @(negedge clk);
    check("ready_after_done", int'(ready), 1);
    check("done_cleared", int'(done), 0);
    check("y_held", int'(y), int'(exp_y));
  endtask

  initial begin
    int done_seen;

    vecs[0] = '{7'b1011010, 3'd3, 1'b0, 7'b0001011};
    vecs[1] = '{7'b1011010, 3'd3, 1'b1, 7'b1111011};
    vecs[2] = '{7'b0101101, 3'd2, 1'b1, 7'b0001011};
    vecs[3] = '{7'h55,      3'd0, 1'b0, 7'h55};
    vecs[4] = '{7'h2A,      3'd0, 1'b1, 7'h2A};   // back-to-back after f=0
    vecs[5] = '{7'b1000000, 3'd7, 1'b1, 7'h7F};
    vecs[6] = '{7'b1000000, 3'd7, 1'b0, 7'h00};
    vecs[7] = '{7'h55,      3'd1, 1'b1, 7'h6A};
    vecs[8] = '{7'h3C,      3'd5, 1'b1, 7'h01};
    vecs[9] = '{7'h40,      3'd6, 1'b1, 7'h7F};

    // Reset held with start asserted: reset wins.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 7'h7F;
    f     = 3'd3;
    arith = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_y", int'(y), 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("idle_y", int'(y), 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].f, vecs[i].arith, vecs[i].exp_y);
    end

    // Extra starts while busy are ignored; only one done.
    start = 1'b1;
    a     = 7'h7F;
    f     = 3'd4;
    arith = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 7'h00;
      f     = 3'(k);
      arith = k[0];
      @(negedge clk);
      check($sformatf("proto_done_c%0d", k), int'(done), (k == 5) ? 1 : 0);
      if (k == 5) check("proto_y", int'(y), 7'h07);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("proto_nodone_c%0d", k), int'(done), 0);
      check($sformatf("proto_yhold_c%0d", k), int'(y), 7'h07);
    end

    // Reset in the middle of an f=6 operation.
    start = 1'b1;
    a     = 7'h7F;
    f     = 3'd6;
    arith = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mid_busy", int'(ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_y", int'(y), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_late_done", done_seen, 0);
    run_op(7'h40, 3'd1, 1'b0, 7'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rsh_iter.md
# rsh_iter

Iterative 7-bit right shifter, the right-shift counterpart to the combinational left shifter in the datapath. It takes a 7-bit operand and a 3-bit shift amount, and shifts one bit position per clock. Logical or arithmetic fill is selectable. It sits beside the left shifter in the small ALU, and the controller talks to it through a start/ready/done handshake.

## Interface

Parameters:
- `W`, default 7: operand width.
- `SW`, default 3: shift-amount width, equal to clog2(W+1).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: request a shift; accepted only when `ready`=1.
- `a`, in, W: operand; sampled only on an accepted start.
- `f`, in, SW: shift amount, 0..7; sampled on an accepted start.
- `arith`, in, 1: fill mode, sampled on an accepted start. 1 = fill with a[W-1] (sign); 0 = fill with 0.
- `ready`, out, 1: block is idle and can accept `start`.
- `done`, out, 1: one-cycle pulse; `y` is the final result in this cycle.
- `y`, out, W: result register; holds its value until the next accepted start.

## Operation

States: IDLE, SHIFT, DONE.

IDLE:
- `ready`=1.
- `start`=1 loads `y`←`a`, `cnt`←`f`, `fill`←`arith & a[W-1]`.
- If `f`=0, next state is DONE; otherwise next state is SHIFT.

SHIFT:
- `ready`=0.
- Each cycle: `y`←{`fill`, `y`[W-1:1]} and `cnt`←`cnt`−1.
- When the shift that takes `cnt` from 1 to 0 occurs, next state is DONE.

DONE:
- `done`=1 and `ready`=0 for exactly one cycle.
- Next state is IDLE unconditionally.

Other rules:
- `start` in SHIFT or DONE is ignored; no queuing.
- `a`, `f` and `arith` are don't-care after acceptance. Changes to them mid-operation do not affect the result.
- `fill` is fixed at acceptance. Fill bits are constant across the whole operation.
- `f`=7 gives all fill bits: 7'h7F if arithmetic with a negative operand, else 7'h00.
- `f` values above W (not reachable with W=7, SW=3) are defined by the same counting rule. Results saturate to all fill bits.
- `y` is not updated in IDLE or DONE.

## Timing

Reset values (with `rst_n`=0 at an edge):
- State = IDLE, `y`=0, `cnt`=0, `fill`=0.
- `ready`=1, `done`=0, from the cycle after that edge.

Latency, with start accepted in cycle 0:
- Shifts occur at the edges ending cycles 1..f.
- `done`=1 in cycle f+1, with the final `y` visible in that cycle.
- `ready`=1 again in cycle f+2.
- Minimum latency is 1 (f=0). Maximum is 8 (f=7).
- Issue interval is f+2 cycles.

Output decoding:
- `ready` and `done` are decoded from registered state only. There is no combinational path from inputs to outputs.

Reset mid-operation:
- Reset in any state aborts the operation.
- No `done` pulse is produced for the aborted operation.
- `y` is cleared to 0.

Reset and start together:
- Reset has priority over `start` in the same cycle.

## Structure

- Package `rsh_pkg` holds:
  - `W` and `SW` as localparams.
  - Enum type `rsh_state_t` = {IDLE, SHIFT, DONE}, 2-bit encoding.
- Single module with no sub-module.
- The shift counter and the data register are inline.

## Test plan

1. Logical shift: `a`=7'b1011010, `f`=3, `arith`=0, start in cycle 0 → `done` in cycle 4, `y`=7'b0001011; `ready`=1 in cycle 5.
2. Arithmetic shift: `a`=7'b1011010, `f`=3, `arith`=1 → `y`=7'b1111011 in cycle 4. Same operand with `arith`=1 and `a[6]`=0 (7'b0101101, `f`=2) → 7'b0001011.
3. Zero shift: `a`=7'h55, `f`=0 → `done` in cycle 1, `y`=7'h55; back-to-back start in cycle 2 accepted.
4. Full shift: `a`=7'b1000000, `f`=7, `arith`=1 → `y`=7'h7F at cycle 8. Same operand with `arith`=0 → 7'h00.
5. Protocol: start at cycle 0 (`a`=7'h7F, `f`=4, `arith`=0), then start pulses with `a`=7'h00 in cycles 1..5, plus `a`/`f` toggled while busy → only one `done` (cycle 5), `y`=7'h07. The extra starts are ignored.
6. Reset mid-shift: `rst_n`=0 at cycle 2 of an `f`=6 operation → next cycle `y`=0, `ready`=1, `done`=0, and no later `done`. A following `a`=7'h40, `f`=1 operation → `y`=7'h20.
